// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobel window sequencer.
// Holds pixel/coordinate widths, sobel latency, default frame geometry,
// the controller state enum and the coordinate payload carried with results.
// Optional feature macro used by the top: SOBEL_EDGE_COUNT_EN.
package sobel_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned COORD_W    = 10;
    localparam int unsigned SOBEL_LAT  = 3;
    localparam int unsigned DEF_WIDTH  = 640;
    localparam int unsigned DEF_HEIGHT = 480;
    localparam int unsigned EDGE_CNT_W = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Window centre coordinate travelling alongside each result
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Dual line buffer, WIDTH entries of PIX_W bits per line.
// Row1 holds the previous line, row2 the line before that. A write at a column
// pushes the old row1 value down into row2 and stores the new pixel in row1.
// Reads are combinational; contents are intentionally not reset.
// Ports:
//   clock     in   clock, rising edge
//   wr_en_i   in   write strobe (one accepted pixel)
//   addr_i    in   column address
//   din_i     in   incoming pixel
//   row1_c_o  out  stored value at addr_i from the previous line (comb)
//   row2_c_o  out  stored value at addr_i from two lines back (comb)
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] row1_c_o,
    output logic [PIX_W-1:0] row2_c_o
);

    logic [PIX_W-1:0] lb_a [WIDTH];
    logic [PIX_W-1:0] lb_b [WIDTH];

    assign row1_c_o = lb_a[addr_i];
    assign row2_c_o = lb_b[addr_i];

    // Shift the column down one line on every write
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            lb_b[addr_i] <= lb_a[addr_i];
            lb_a[addr_i] <= din_i;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequencer for the sobel edge datapath: builds the 3x3 window from a raster
// pixel stream, tags the downstream sobel result with valid and centre (x,y),
// and flags end-of-frame and aborted frames.
// Optional: define SOBEL_EDGE_COUNT_EN to add edge_count (saturated-edge tally
// per completed frame).
// Ports:
//   clock, reset_n            clock / async active-low reset
//   pix_in, pix_valid         pixel stream, accepted when pix_valid=1
//   frame_start               marks the accepted pixel as (0,0)
//   z0..z8, win_valid         window to sobel (top, mid, newest row; left to right)
//   edge_in                   sobel result input
//   edge_out                  edge_in forwarded combinationally
//   edge_valid, edge_x/_y     result valid and its window centre
//   frame_done, frame_err     end-of-frame / abort pulses
//   edge_count                (SOBEL_EDGE_COUNT_EN) count of 8'hff results
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               frame_start,
    output logic [PIX_W-1:0]   z0,
    output logic [PIX_W-1:0]   z1,
    output logic [PIX_W-1:0]   z2,
    output logic [PIX_W-1:0]   z3,
    output logic [PIX_W-1:0]   z4,
    output logic [PIX_W-1:0]   z5,
    output logic [PIX_W-1:0]   z6,
    output logic [PIX_W-1:0]   z7,
    output logic [PIX_W-1:0]   z8,
    output logic               win_valid,
    input  logic [PIX_W-1:0]   edge_in,
    output logic [PIX_W-1:0]   edge_out,
    output logic               edge_valid,
    output logic [COORD_W-1:0] edge_x,
    output logic [COORD_W-1:0] edge_y,
    output logic               frame_done,
`ifdef SOBEL_EDGE_COUNT_EN
    output logic               frame_err,
    output logic [EDGE_CNT_W-1:0] edge_count
`else
    output logic               frame_err
`endif
);

    localparam int unsigned AW = $clog2(WIDTH);

    state_e                      state_q, state_d;
    logic [COORD_W-1:0]          col_q, col_d, row_q, row_d;
    logic [8:0][PIX_W-1:0]       win_q, win_d;
    logic                        win_valid_q, win_valid_d;
    coord_t                      win_c_q, win_c_d;
    logic [SOBEL_LAT-1:0]        pipe_v_q, pipe_v_d;
    coord_t [SOBEL_LAT-1:0]      pipe_c_q, pipe_c_d;
    logic                        drain_q, drain_d;
    logic                        frame_done_q, frame_done_d;
    logic                        frame_err_q, frame_err_d;

    logic                        in_frame, accept, abort, col_end, last_px;
    logic                        win_fire, done_fire;
    logic [COORD_W-1:0]          cur_col, cur_row;
    logic [PIX_W-1:0]            lb_mid, lb_top;

    // Qualify the incoming pixel and locate it in the frame
    always_comb begin
        in_frame  = (state_q == FILL) || (state_q == RUN);
        accept    = pix_valid && (frame_start || in_frame);
        abort     = pix_valid && frame_start && in_frame;
        cur_col   = frame_start ? '0 : col_q;
        cur_row   = frame_start ? '0 : row_q;
        col_end   = (cur_col == COORD_W'(WIDTH - 1));
        last_px   = col_end && (cur_row == COORD_W'(HEIGHT - 1));
        win_fire  = accept && !frame_start &&
                    (row_q >= COORD_W'(2)) && (col_q >= COORD_W'(2));
        // Last in-flight result is on edge_valid now and nothing follows it
        done_fire = drain_q && !win_valid_q &&
                    (pipe_v_q == {1'b1, {(SOBEL_LAT-1){1'b0}}});
    end

    sobel_line_buffer #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_line_buffer (
        .clock    (clock),
        .wr_en_i  (accept),
        .addr_i   (AW'(cur_col)),
        .din_i    (pix_in),
        .row1_c_o (lb_mid),
        .row2_c_o (lb_top)
    );

    // Next-state: FSM, counters, window shift and valid pipe
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        win_c_d      = win_c_q;
        pipe_v_d     = {pipe_v_q[SOBEL_LAT-2:0], win_valid_q};
        pipe_c_d     = {pipe_c_q[SOBEL_LAT-2:0], win_c_q};
        drain_d      = drain_q;
        frame_done_d = done_fire;
        frame_err_d  = abort;

        if (done_fire) begin
            drain_d = 1'b0;
        end

        if (accept) begin
            win_d = {pix_in, win_q[8], win_q[7],
                     lb_mid, win_q[5], win_q[4],
                     lb_top, win_q[2], win_q[1]};

            if (col_end) begin
                col_d = '0;
                row_d = last_px ? '0 : cur_row + COORD_W'(1);
            end else begin
                col_d = cur_col + COORD_W'(1);
                row_d = cur_row;
            end

            if (win_fire) begin
                win_valid_d = 1'b1;
                win_c_d.x   = col_q - COORD_W'(1);
                win_c_d.y   = row_q - COORD_W'(1);
            end

            if (frame_start) begin
                state_d = FILL;
            end else if ((state_q == FILL) && col_end && (cur_row == COORD_W'(1))) begin
                state_d = RUN;
            end else if ((state_q == RUN) && last_px) begin
                state_d = DRAIN;
                drain_d = 1'b1;
            end
        end else if ((state_q == DRAIN) && done_fire) begin
            state_d = IDLE;
        end

        // An abort discards everything in flight from the old frame
        if (abort) begin
            pipe_v_d = '0;
            drain_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_c_q      <= '0;
            pipe_v_q     <= '0;
            pipe_c_q     <= '0;
            drain_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_c_q      <= win_c_d;
            pipe_v_q     <= pipe_v_d;
            pipe_c_q     <= pipe_c_d;
            drain_q      <= drain_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef SOBEL_EDGE_COUNT_EN
    logic [EDGE_CNT_W-1:0] cnt_q, cnt_d, edge_count_q, edge_count_d;
    logic                  hit;

    // Tally saturated results; publish on frame_done, discard on abort
    always_comb begin
        hit          = edge_valid && (edge_in == 8'hff);
        cnt_d        = cnt_q;
        edge_count_d = edge_count_q;
        if (done_fire) begin
            edge_count_d = cnt_q + EDGE_CNT_W'(hit);
            cnt_d        = '0;
        end else if (hit) begin
            cnt_d = cnt_q + EDGE_CNT_W'(1);
        end
        if (abort) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            edge_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign edge_count = edge_count_q;
`endif

    assign z0         = win_q[0];
    assign z1         = win_q[1];
    assign z2         = win_q[2];
    assign z3         = win_q[3];
    assign z4         = win_q[4];
    assign z5         = win_q[5];
    assign z6         = win_q[6];
    assign z7         = win_q[7];
    assign z8         = win_q[8];
    assign win_valid  = win_valid_q;
    assign edge_out   = edge_in;
    assign edge_valid = pipe_v_q[SOBEL_LAT-1];
    assign edge_x     = pipe_c_q[SOBEL_LAT-1].x;
    assign edge_y     = pipe_c_q[SOBEL_LAT-1].y;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x6 frame with a behavioural
// 3-stage sobel downstream feeding edge_in.
module tb_sobel_window_ctrl;

    localparam int W = 8;
    localparam int H = 6;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       pix_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
    logic       win_valid;
    logic [7:0] edge_in, edge_out;
    logic       edge_valid;
    logic [9:0] edge_x, edge_y;
    logic       frame_done, frame_err;
`ifdef SOBEL_EDGE_COUNT_EN
    logic [19:0] edge_count;
`endif

    sobel_window_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .z0 (z0), .z1 (z1), .z2 (z2),
        .z3 (z3), .z4 (z4), .z5 (z5),
        .z6 (z6), .z7 (z7), .z8 (z8),
        .win_valid   (win_valid),
        .edge_in     (edge_in),
        .edge_out    (edge_out),
        .edge_valid  (edge_valid),
        .edge_x      (edge_x),
        .edge_y      (edge_y),
        .frame_done  (frame_done),
`ifdef SOBEL_EDGE_COUNT_EN
        .frame_err   (frame_err),
        .edge_count  (edge_count)
`else
        .frame_err   (frame_err)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural sobel: |gx|+|gy| saturated, 3 register stages
    function automatic logic [7:0] sob(input logic [8:0][7:0] w);
        int gx, gy, m;
        gx = (int'(w[2]) + 2*int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[3]) + int'(w[6]));
        gy = (int'(w[6]) + 2*int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[1]) + int'(w[2]));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        return (m > 255) ? 8'hff : 8'(m);
    endfunction

    logic [7:0] s1 = 8'd0, s2 = 8'd0, s3 = 8'd0;
    always @(posedge clock) begin
        s1 <= sob({z8, z7, z6, z5, z4, z3, z2, z1, z0});
        s2 <= s1;
        s3 <= s2;
    end
    assign edge_in = s3;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Result recorder
    int res_x[$], res_y[$], res_e[$], res_c[$];
    int done_n = 0, err_n = 0, win_n = 0, done_cyc = -1;
    always @(negedge clock) begin
        if (edge_valid) begin
            res_x.push_back(int'(edge_x));
            res_y.push_back(int'(edge_y));
            res_e.push_back(int'(edge_out));
            res_c.push_back(cyc);
        end
        if (frame_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (frame_err) err_n++;
        if (win_valid) win_n++;
    end

    int checks = 0;
    int errors = 0;
    int f0 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            pix_valid   = 1'b0;
            frame_start = 1'b0;
            pix_in      = 8'h5a;
        end
    endtask

    task automatic send_pix(input logic [7:0] v, input bit fs);
        @(negedge clock);
        pix_in      = v;
        pix_valid   = 1'b1;
        frame_start = fs;
    endtask

    function automatic logic [7:0] pix_val(input int kind, input int x);
        if (kind == 0) return 8'h40;
        return (x >= 4) ? 8'hff : 8'h00;
    endfunction

    function automatic int exp_edge(input int kind, input int x);
        if (kind == 0) return 0;
        return (x == 3 || x == 4) ? 255 : 0;
    endfunction

    task automatic send_frame(input int kind, input bit rnd, input int npix,
                              output int t22, output int t0);
        t22 = -100;
        t0  = -100;
        for (int i = 0; i < npix; i++) begin
            int x;
            int y;
            x = i % W;
            y = i / W;
            if (rnd && ($urandom_range(1) == 0)) idle(1);
            send_pix(pix_val(kind, x), i == 0);
            if (i == 0) t0 = cyc;
            if (x == 2 && y == 2) t22 = cyc;
        end
    endtask

    task automatic verify(input string tag, input int kind, input int base);
        int bad_c, bad_v, idx;
        bad_c = 0;
        bad_v = 0;
        idx   = base;
        check({tag, "_count"}, 32'(res_x.size() - base), 32'd24);
        for (int y = 1; y <= H - 2; y++) begin
            for (int x = 1; x <= W - 2; x++) begin
                if (idx < res_x.size()) begin
                    if (res_x[idx] != x || res_y[idx] != y) bad_c++;
                    if (res_e[idx] != exp_edge(kind, x)) bad_v++;
                end
                idx++;
            end
        end
        check({tag, "_coords"}, 32'(bad_c), 32'd0);
        check({tag, "_values"}, 32'(bad_v), 32'd0);
    endtask

    task automatic full_frame(input string tag, input int kind, input bit rnd, input int base);
        int t22, t0, prev, lat, gap;
        prev = done_n;
        send_frame(kind, rnd, W * H, t22, t0);
        f0 = t0;
        idle(1);
        for (int i = 0; i < 40 && done_n == prev; i++) idle(1);
        idle(2);
        check({tag, "_done"}, 32'(done_n), 32'(prev + 1));
        verify(tag, kind, base);
        lat = (res_c.size() > base) ? res_c[base] - t22 : -1;
        check({tag, "_latency"}, 32'(lat), 32'd4);
        gap = (res_c.size() > 0) ? done_cyc - res_c[res_c.size() - 1] : -1;
        check({tag, "_done_gap"}, 32'(gap), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int b, e0, n;

        // 1. reset state, then pixels without frame_start
        repeat (3) @(negedge clock);
        check("rst_flags", {28'd0, win_valid, edge_valid, frame_done, frame_err}, 32'd0);
        check("rst_xy", {12'd0, edge_x, edge_y}, 32'd0);
        check("rst_z", {24'd0, z0 | z1 | z2 | z3 | z4 | z5 | z6 | z7 | z8}, 32'd0);
        check("rst_edge_out", {24'd0, edge_out}, 32'd0);
`ifdef SOBEL_EDGE_COUNT_EN
        check("rst_edge_count", {12'd0, edge_count}, 32'd0);
`endif
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_pix(8'h40, 1'b0);
            idle(1);
        end
        idle(6);
        check("nostart_win", 32'(win_n), 32'd0);
        check("nostart_res", 32'(res_x.size()), 32'd0);

        // 2. flat frame
        full_frame("flat", 0, 1'b0, res_x.size());
`ifdef SOBEL_EDGE_COUNT_EN
        check("flat_edge_count", {12'd0, edge_count}, 32'd0);
`endif

        // 3. vertical step
        idle(3);
        full_frame("step", 1, 1'b0, res_x.size());
`ifdef SOBEL_EDGE_COUNT_EN
        check("step_edge_count", {12'd0, edge_count}, 32'd8);
`endif

        // 4. vertical step with gapped pix_valid
        idle(3);
        full_frame("gap", 1, 1'b1, res_x.size());
`ifdef SOBEL_EDGE_COUNT_EN
        check("gap_edge_count", {12'd0, edge_count}, 32'd8);
`endif

        // 5. abort at pixel (5,3): 6 row-1 results precede the new frame's 24
        idle(3);
        b  = res_x.size();
        e0 = err_n;
        for (int i = 0; i < 3 * W + 5; i++) send_pix(pix_val(1, i % W), i == 0);
        full_frame("abort", 1, 1'b0, b + 6);
        check("abort_err", 32'(err_n - e0), 32'd1);
        n = 0;
        foreach (res_c[i]) if (res_c[i] > f0 && res_c[i] <= f0 + 12) n++;
        check("abort_stale", 32'(n), 32'd0);
`ifdef SOBEL_EDGE_COUNT_EN
        check("abort_edge_count", {12'd0, edge_count}, 32'd8);
`endif

        // 6. reset pulse mid-RUN, then a clean frame
        idle(3);
        for (int i = 0; i < 3 * W + 7; i++) send_pix(pix_val(1, i % W), i == 0);
        @(negedge clock);
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        check("prerst_edge_valid", {31'd0, edge_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("rst_edge_valid_drop", {31'd0, edge_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        b = res_x.size();
        idle(8);
        check("postrst_quiet", 32'(res_x.size() - b), 32'd0);
`ifdef SOBEL_EDGE_COUNT_EN
        check("postrst_edge_count", {12'd0, edge_count}, 32'd0);
`endif
        full_frame("postrst", 1, 1'b0, res_x.size());
`ifdef SOBEL_EDGE_COUNT_EN
        check("postrst_final_count", {12'd0, edge_count}, 32'd8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
